// File: rtl/addsub_prefix_pipe_if.sv
// Operand/result handshake bundle for addsub_prefix_pipe.
// master = producer/consumer side, slave = the adder pipeline.
interface addsub_prefix_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_prefix_pipe.sv
// Pipelined Kogge-Stone add/subtract with valid/ready flow control.
// Define ADDSUB_PREFIX_SAT_EN to saturate s on signed overflow.
module addsub_prefix_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input logic                clk,
  input logic                reset_n,
  addsub_prefix_pipe_if.slave bus
);
  localparam int unsigned Levels = $clog2(WIDTH);

  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             sum_cout;
  logic             sum_ovf;
  logic             res_zero;

  assign cin   = bus.op;
  assign b_eff = bus.op ? ~bus.b : bus.b;

  // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
  for (genvar l = 0; l <= Levels; l++) begin : g_level
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    if (l == 0) begin : g_init
      assign pp = bus.a ^ b_eff;
      assign gg = (bus.a & b_eff) | {{(WIDTH-1){1'b0}}, pp[0] & cin};
    end else begin : g_comb
      localparam int unsigned Dist = 1 << (l - 1);
      assign gg = g_level[l-1].gg |
                  (g_level[l-1].pp & {g_level[l-1].gg[WIDTH-1-Dist:0], {Dist{1'b0}}});
      assign pp = g_level[l-1].pp & {g_level[l-1].pp[WIDTH-1-Dist:0], {Dist{1'b1}}};
    end
  end

  assign sum      = g_level[0].pp ^ {g_level[Levels].gg[WIDTH-2:0], cin};
  assign sum_cout = g_level[Levels].gg[WIDTH-1];
  assign sum_ovf  = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);

`ifdef ADDSUB_PREFIX_SAT_EN
  always_comb begin
    res = sum;
    if (sum_ovf) begin
      res = bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res = sum;
`endif

  assign res_zero = (res == '0);

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
  logic [STAGES-1:0]            cout_q, cout_d;
  logic [STAGES-1:0]            ovf_q, ovf_d;
  logic [STAGES-1:0]            zero_q, zero_d;
  logic                         advance;

  // Reset empties the pipe, so in_ready reads high while reset is held.
  assign advance      = !vld_q[STAGES-1] || bus.out_ready || !reset_n;
  assign bus.in_ready = advance;

  // Data registers only load behind a valid bit; bubbles leave them untouched.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_d[0]  = bus.in_valid;
      assign s_d[0]    = bus.in_valid ? res      : s_q[0];
      assign cout_d[0] = bus.in_valid ? sum_cout : cout_q[0];
      assign ovf_d[0]  = bus.in_valid ? sum_ovf  : ovf_q[0];
      assign zero_d[0] = bus.in_valid ? res_zero : zero_q[0];
    end else begin : g_tail
      assign vld_d[k]  = vld_q[k-1];
      assign s_d[k]    = vld_q[k-1] ? s_q[k-1]    : s_q[k];
      assign cout_d[k] = vld_q[k-1] ? cout_q[k-1] : cout_q[k];
      assign ovf_d[k]  = vld_q[k-1] ? ovf_q[k-1]  : ovf_q[k];
      assign zero_d[k] = vld_q[k-1] ? zero_q[k-1] : zero_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q  <= '0;
      s_q    <= '0;
      cout_q <= '0;
      ovf_q  <= '0;
      zero_q <= '0;
    end else if (advance) begin
      vld_q  <= vld_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.s         = s_q[STAGES-1];
  assign bus.cout      = cout_q[STAGES-1];
  assign bus.ovf       = ovf_q[STAGES-1];
  assign bus.zero      = zero_q[STAGES-1];
endmodule

// File: tb/tb_addsub_prefix_pipe.sv
// Bench for addsub_prefix_pipe: directed vector table, stall/reset sequences and
// randomized traffic against an integer-arithmetic reference model.
module tb_addsub_prefix_pipe;
  localparam int unsigned W  = 16;
  localparam int unsigned St = 2;
  localparam int MaxS = (1 << (W - 1)) - 1;
  localparam int MinS = -(1 << (W - 1));

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  addsub_prefix_pipe_if #(.WIDTH(W)) bus ();

  addsub_prefix_pipe #(.WIDTH(W), .STAGES(St)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  localparam int NVec = 7;
  vec_t vecs [NVec];

  int total = 0;
  int bad   = 0;

  logic [W+2:0] exp_q [$];
  logic         held_v = 1'b0;
  logic [W+3:0] held;

  // {s, cout, ovf, zero} from signed/unsigned integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
    int sa, sb, r;
    logic [W-1:0] s;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = op ? sa - sb : sa + sb;
    c  = op ? (a >= b) : ((int'(a) + int'(b)) >= (1 << W));
    s  = r[W-1:0];
    v  = (r > MaxS) || (r < MinS);
`ifdef ADDSUB_PREFIX_SAT_EN
    if (r > MaxS) s = {1'b0, {(W-1){1'b1}}};
    if (r < MinS) s = {1'b1, {(W-1){1'b0}}};
`endif
    return {s, c, v, (s == '0)};
  endfunction

  function automatic logic [W+3:0] cur();
    return {bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero};
  endfunction

  task automatic check(input string name, input logic [W+3:0] got, input logic [W+3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got v=%b s=%h c=%b o=%b z=%b, want v=%b s=%h c=%b o=%b z=%b", name,
               got[W+3], got[W+2:3], got[2], got[1], got[0],
               exp[W+3], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Inputs are driven at posedge+1; sample at posedge+2, then advance one clock.
  task automatic step(output logic acc);
    logic emit;
    logic [W+2:0] e;
    #1;
    if (held_v) check("stall_hold", cur(), held);
    check_int("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
    acc  = bus.in_valid && bus.in_ready;
    emit = bus.out_valid && bus.out_ready;
    if (emit) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_result: got s=%h with no transfer pending, want none", bus.s);
      end else begin
        e = exp_q.pop_front();
        check("result", cur(), {1'b1, e});
      end
    end
    if (acc) exp_q.push_back(model(bus.a, bus.b, bus.op));
    held_v = bus.out_valid && !bus.out_ready;
    held   = cur();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int n, cyc;

    vecs[0] = '{16'd980,   16'd722, 1'b1, 16'd258,  1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'd0,     16'd1,   1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'd65535, 16'd1,   1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'd5,     16'd5,   1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_PREFIX_SAT_EN
    vecs[3] = '{16'h7FFF,  16'd1,   1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000,  16'd1,   1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h8000,  16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
`else
    vecs[3] = '{16'h7FFF,  16'd1,   1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000,  16'd1,   1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h8000,  16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
`endif

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_outputs", cur(), '0);
    reset_n = 1'b1;

    // Directed vectors: exact latency and result fields.
    for (int i = 0; i < NVec; i++) begin
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      bus.op       = vecs[i].op;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_int("latency_early", int'(bus.out_valid), 0);
      repeat (St - 1) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), cur(),
            {1'b1, vecs[i].s, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
      @(posedge clk);
      #1;
      check_int("vec_drained", int'(bus.out_valid), 0);
    end

    // Five-transfer stream with a three-cycle consumer stall.
    n   = 0;
    cyc = 0;
    while ((n < 5 || exp_q.size() != 0) && cyc < 40) begin
      bus.in_valid  = (n < 5);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.op        = 1'($urandom_range(0, 1));
      bus.out_ready = !(cyc >= 2 && cyc < 5);
      step(acc);
      if (acc) n++;
      cyc++;
    end
    check_int("stream_sent", n, 5);
    check_int("stream_drained", exp_q.size(), 0);

    // Two transfers in flight, then a one-edge reset with in_valid held high.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'(100 + i);
      bus.b        = 16'd3;
      bus.op       = 1'b0;
      step(acc);
    end
    reset_n = 1'b0;
    bus.a   = 16'h1234;
    #1;
    check_int("reset_in_ready_stalled", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("reset_flush", cur(), '0);
    exp_q.delete();
    held_v = 1'b0;
    repeat (6) step(acc);

    // Randomized traffic with corner-biased operands and random back-pressure.
    n   = 0;
    cyc = 0;
    while (n < 1000 && cyc < 8000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 8);
      bus.a         = ($urandom_range(0, 7) == 0) ? 16'h7FFF : W'($urandom);
      bus.b         = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
      bus.op        = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
      if (acc) n++;
      cyc++;
    end
    check_int("random_sent", n, 1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (St + 2) step(acc);
    check_int("random_drained", exp_q.size(), 0);
    check_int("final_out_valid", int'(bus.out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
